maze_update_scheduler: RTL and testbench
========================================

// Module: maze_update_scheduler
// PURPOSE
//  Sequences tile-update words from the radio receiver into the maze display's DATA_IN/DATA_VAL write port.
//  Buffers bursts in a small FIFO and paces writes. Drops out-of-grid coordinates.
//  Auto-retracts the previous robot-position marker (bit 1) when the robot moves.
//  Arbitrates against a full-grid clear sweep requested by the board button.
// PARAMETERS
//  FIFO_DEPTH  4  entries in the RX word FIFO; power of 2, >=2
//  GRID_W      5  tile columns; valid x = 0..GRID_W-1
//  GRID_H      4  tile rows; valid y = 0..GRID_H-1
//  GAP_CYCLES  1  idle cycles forced after every DATA_VAL pulse; 0 = back-to-back
// PORTS
//  CLK         in   1   system clock (50 MHz)
//  RST_N       in   1   asynchronous active-low reset
//  RX_DATA     in   16  update word: [15:13]=x, [12:11]=y, [10:8]=0, [7:0]=tile bits
//                       tile bits: 0 done, 1 robot here, 2 explored, 3-6 walls
//  RX_VAL      in   1   one-cycle strobe, RX_DATA valid; no back-pressure
//  CLEAR_REQ   in   1   one-cycle strobe requesting a full-grid clear
//  DATA_OUT    out  16  word to the display grid, same format as RX_DATA
//  DATA_VAL    out  1   one-cycle write strobe for DATA_OUT
//  CLEAR_BUSY  out  1   high while the clear sweep runs
//  OVERFLOW    out  1   sticky: an RX word was dropped because the FIFO was full
//  BAD_COORD   out  1   sticky: a popped word had x>=GRID_W or y>=GRID_H
//  DONE        out  1   latched: an issued word had bit 0 set
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, pos_valid=0, clear_pend=0, FSM=IDLE. All outputs are registered.
//  FIFO push:
//   - RX_VAL=1 and FIFO not full (evaluated before any same-cycle pop) -> push.
//   - RX_VAL=1 and FIFO full -> word dropped, OVERFLOW<=1.
//  CLEAR_REQ sets clear_pend; ignored while CLEAR_BUSY=1.
//  FSM states:
//   - IDLE:
//     - clear_pend -> CLEAR: flush FIFO, cx=cy=0, clear_pend<=0, CLEAR_BUSY<=1.
//     - else FIFO non-empty -> pop into hold reg.
//       - coordinates out of range -> BAD_COORD<=1, stay IDLE.
//       - otherwise -> ISSUE.
//   - ISSUE:
//     - DATA_OUT<=hold, DATA_VAL<=1 for exactly one cycle.
//     - bit0 set -> DONE<=1.
//     - Shadow tracking:
//       - hold.bit1=1 and pos_valid and (x,y)!=(px,py) -> retract needed.
//       - hold.bit1=1 -> {px,py,pdata}<=hold, pos_valid<=1.
//       - hold.bit1=0 and (x,y)==(px,py) -> pos_valid<=0.
//     - Next state: RETRACT if retract needed, else GAP.
//   - RETRACT:
//     - Enter via GAP (gap still honoured).
//     - DATA_OUT<={px_old,py_old,3'b0,pdata_old & 8'hFD}, DATA_VAL pulse; -> GAP.
//   - GAP:
//     - Count GAP_CYCLES with DATA_VAL=0; then -> pending RETRACT / CLEAR step, else IDLE.
//     - GAP_CYCLES=0: GAP is skipped.
//   - CLEAR:
//     - Writes {cx,cy,11'b0} one word per (1+GAP_CYCLES) cycles; y inner loop, x outer.
//     - Last word is (GRID_W-1,GRID_H-1); then CLEAR_BUSY<=0, pos_valid<=0, DONE<=0, -> IDLE.
//     - RX pushes continue during CLEAR; only the entry flush discards.
//  Priority at IDLE: retract (via GAP) > clear_pend > FIFO.
//  A CLEAR_REQ arriving mid ISSUE/RETRACT waits until that pair completes.
//  Latency: RX_VAL at cycle N into empty FIFO, FSM idle -> DATA_VAL high at cycle N+2.
//  Async reset mid-sweep or mid-write: immediate return to reset state; no partial pulse is stretched.
//  DATA_VAL never asserts on two consecutive cycles when GAP_CYCLES>=1.
// TESTING
//  1. Reset, RX_VAL with 16'h2006 (x1,y0, robot+explored) -> DATA_VAL at N+2, DATA_OUT=16'h2006; pos_valid set.
//  2. Then RX 16'h4006 (x2,y0) -> DATA_OUT 16'h4006, gap cycle, then DATA_OUT 16'h2004 (retract).
//  3. Push 6 words in 6 consecutive cycles, FIFO_DEPTH=4, FSM idle -> 5 words issued in order, OVERFLOW=1.
//  4. RX 16'hA000 (x5) -> no DATA_VAL, BAD_COORD=1; next valid word still issued.
//  5. CLEAR_REQ while 2 words queued -> 20 writes (GRID_W*GRID_H) of data 0, y-inner order.
//     Each write 2 cycles apart; queued words lost; CLEAR_BUSY high throughout; DONE=0 after.
//  6. RX 16'h0001 -> DONE=1; assert RST_N=0 mid-CLEAR -> all outputs 0 immediately; no DATA_VAL after release.

Source files
------------

// File: rtl/maze_update_scheduler.sv
// Paces radio tile-update words into the maze display write port: small RX FIFO,
// coordinate filtering, automatic retraction of the old robot marker, and a full-grid clear sweep.
module maze_update_scheduler #(
    parameter int FIFO_DEPTH = 4,
    parameter int GRID_W     = 5,
    parameter int GRID_H     = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] RX_DATA,
    input  logic        RX_VAL,
    input  logic        CLEAR_REQ,
    output logic [15:0] DATA_OUT,
    output logic        DATA_VAL,
    output logic        CLEAR_BUSY,
    output logic        OVERFLOW,
    output logic        BAD_COORD,
    output logic        DONE,
    output logic [2:0]  FSM_STATE
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    // ISSUE, RETRACT and CLEAR are the cycles in which DATA_VAL is high.
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_RETRACT, S_GAP, S_CLEAR} state_t;

    state_t        state_q, state_d;
    logic [15:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [15:0]   dout_q, dout_d, ret_word_q, ret_word_d;
    logic          dval_q, dval_d, busy_q, busy_d, ovf_q, ovf_d, bad_q, bad_d, done_q, done_d;
    logic          clear_pend_q, clear_pend_d, ret_pend_q, ret_pend_d, pos_valid_q, pos_valid_d;
    logic [2:0]    px_q, px_d, cx_q, cx_d, nx;
    logic [1:0]    py_q, py_d, cy_q, cy_d, ny;
    logic [7:0]    pdata_q, pdata_d;
    logic [15:0]   head;
    logic          push, pop, flush, do_post, coord_ok, clear_last;

    assign head       = mem_q[rd_q];
    assign coord_ok   = (32'(head[15:13]) < GRID_W) && (32'(head[12:11]) < GRID_H);
    assign push       = RX_VAL && (cnt_q != CW'(FIFO_DEPTH));
    assign clear_last = (cx_q == 3'(GRID_W - 1)) && (cy_q == 2'(GRID_H - 1));
    assign nx         = (cy_q == 2'(GRID_H - 1)) ? cx_q + 3'd1 : cx_q;
    assign ny         = (cy_q == 2'(GRID_H - 1)) ? 2'd0 : cy_q + 2'd1;

    always_comb begin
        state_d      = state_q;
        gap_d        = gap_q;
        dout_d       = dout_q;
        dval_d       = 1'b0;
        busy_d       = busy_q;
        ovf_d        = ovf_q | (RX_VAL & ~push);
        bad_d        = bad_q;
        done_d       = done_q;
        clear_pend_d = clear_pend_q | (CLEAR_REQ & ~busy_q);
        ret_pend_d   = ret_pend_q;
        ret_word_d   = ret_word_q;
        pos_valid_d  = pos_valid_q;
        px_d         = px_q;
        py_d         = py_q;
        pdata_d      = pdata_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        pop          = 1'b0;
        flush        = 1'b0;
        do_post      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (clear_pend_q) begin
                    flush        = 1'b1;
                    clear_pend_d = 1'b0;
                    busy_d       = 1'b1;
                    cx_d         = 3'd0;
                    cy_d         = 2'd0;
                    dout_d       = 16'h0000;
                    dval_d       = 1'b1;
                    state_d      = S_CLEAR;
                end else if (cnt_q != '0) begin
                    pop = 1'b1;
                    if (!coord_ok) begin
                        bad_d = 1'b1;
                    end else begin
                        dout_d  = head;
                        dval_d  = 1'b1;
                        state_d = S_ISSUE;
                        if (head[0]) done_d = 1'b1;
                        // Shadow of the last robot marker, so a move can erase the old tile's bit 1.
                        if (head[1]) begin
                            if (pos_valid_q && ({head[15:13], head[12:11]} != {px_q, py_q})) begin
                                ret_pend_d = 1'b1;
                                ret_word_d = {px_q, py_q, 3'b000, pdata_q & 8'hFD};
                            end
                            px_d        = head[15:13];
                            py_d        = head[12:11];
                            pdata_d     = head[7:0];
                            pos_valid_d = 1'b1;
                        end else if ({head[15:13], head[12:11]} == {px_q, py_q}) begin
                            pos_valid_d = 1'b0;
                        end
                    end
                end
            end
            S_ISSUE, S_RETRACT, S_CLEAR: begin
                if (state_q == S_CLEAR && clear_last) begin
                    busy_d      = 1'b0;
                    pos_valid_d = 1'b0;
                    done_d      = 1'b0;
                end
                gap_d = '0;
                if (GAP_CYCLES == 0) do_post = 1'b1;
                else                 state_d = S_GAP;
            end
            S_GAP: begin
                if (gap_q == GW'(GAP_CYCLES - 1)) do_post = 1'b1;
                else                              gap_d   = gap_q + GW'(1);
            end
            default: state_d = S_IDLE;
        endcase

        // Work that follows a completed gap: pending retract first, then the next sweep word.
        if (do_post) begin
            if (ret_pend_q) begin
                dout_d     = ret_word_q;
                dval_d     = 1'b1;
                ret_pend_d = 1'b0;
                state_d    = S_RETRACT;
            end else if (busy_d) begin
                dout_d  = {nx, ny, 11'b0};
                cx_d    = nx;
                cy_d    = ny;
                dval_d  = 1'b1;
                state_d = S_CLEAR;
            end else begin
                state_d = S_IDLE;
            end
        end

        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush) begin
            rd_d  = wr_q;
            cnt_d = '0;
        end else begin
            if (push) wr_d = wr_q + AW'(1);
            if (pop)  rd_d = rd_q + AW'(1);
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (push && !flush) mem_q[wr_q] <= RX_DATA;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= S_IDLE;
            wr_q         <= '0;
            rd_q         <= '0;
            cnt_q        <= '0;
            gap_q        <= '0;
            dout_q       <= '0;
            dval_q       <= 1'b0;
            busy_q       <= 1'b0;
            ovf_q        <= 1'b0;
            bad_q        <= 1'b0;
            done_q       <= 1'b0;
            clear_pend_q <= 1'b0;
            ret_pend_q   <= 1'b0;
            ret_word_q   <= '0;
            pos_valid_q  <= 1'b0;
            px_q         <= '0;
            py_q         <= '0;
            pdata_q      <= '0;
            cx_q         <= '0;
            cy_q         <= '0;
        end else begin
            state_q      <= state_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            cnt_q        <= cnt_d;
            gap_q        <= gap_d;
            dout_q       <= dout_d;
            dval_q       <= dval_d;
            busy_q       <= busy_d;
            ovf_q        <= ovf_d;
            bad_q        <= bad_d;
            done_q       <= done_d;
            clear_pend_q <= clear_pend_d;
            ret_pend_q   <= ret_pend_d;
            ret_word_q   <= ret_word_d;
            pos_valid_q  <= pos_valid_d;
            px_q         <= px_d;
            py_q         <= py_d;
            pdata_q      <= pdata_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
        end
    end

    assign DATA_OUT   = dout_q;
    assign DATA_VAL   = dval_q;
    assign CLEAR_BUSY = busy_q;
    assign OVERFLOW   = ovf_q;
    assign BAD_COORD  = bad_q;
    assign DONE       = done_q;
    assign FSM_STATE  = state_q;
endmodule

// File: tb/tb_maze_update_scheduler.sv
// Directed bench for maze_update_scheduler: latency, retract, overflow, bad coordinates,
// clear sweep and asynchronous reset in the middle of a sweep.
module tb_maze_update_scheduler;
    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [15:0] RX_DATA = '0;
    logic        RX_VAL = 1'b0;
    logic        CLEAR_REQ = 1'b0;
    logic [15:0] DATA_OUT;
    logic        DATA_VAL, CLEAR_BUSY, OVERFLOW, BAD_COORD, DONE;
    logic [2:0]  FSM_STATE;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_n = 0;
    int adj_cnt = 0;
    logic prev_dv = 1'b0;
    logic [15:0] exp_q[$];
    int          exp_t[$];
    logic [15:0] got_q[$];
    int          got_t[$];
    logic        got_b[$];

    maze_update_scheduler #(.FIFO_DEPTH(4), .GRID_W(5), .GRID_H(4), .GAP_CYCLES(1)) dut (
        .CLK(CLK), .RST_N(RST_N), .RX_DATA(RX_DATA), .RX_VAL(RX_VAL), .CLEAR_REQ(CLEAR_REQ),
        .DATA_OUT(DATA_OUT), .DATA_VAL(DATA_VAL), .CLEAR_BUSY(CLEAR_BUSY), .OVERFLOW(OVERFLOW),
        .BAD_COORD(BAD_COORD), .DONE(DONE), .FSM_STATE(FSM_STATE)
    );

    always #10 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One clock of stimulus; samples outputs 1 ns after the edge and logs write pulses.
    task automatic cyc(input logic v, input logic [15:0] d, input logic c);
        RX_VAL = v; RX_DATA = d; CLEAR_REQ = c;
        @(posedge CLK); #1;
        RX_VAL = 1'b0; RX_DATA = '0; CLEAR_REQ = 1'b0;
        cyc_n++;
        if (DATA_VAL === 1'b1) begin
            got_q.push_back(DATA_OUT);
            got_t.push_back(cyc_n);
            got_b.push_back(CLEAR_BUSY);
            if (prev_dv) adj_cnt++;
        end
        prev_dv = (DATA_VAL === 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 16'h0000, 1'b0);
    endtask

    task automatic start_capture();
        got_q.delete(); got_t.delete(); got_b.delete();
        exp_q.delete(); exp_t.delete();
        cyc_n = 0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        n_cmp++;
        if ({DATA_OUT, DATA_VAL, CLEAR_BUSY, OVERFLOW, BAD_COORD, DONE, FSM_STATE} !== 24'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got out=%h val=%b busy=%b ovf=%b bad=%b done=%b st=%0d required all zero",
                     DATA_OUT, DATA_VAL, CLEAR_BUSY, OVERFLOW, BAD_COORD, DONE, FSM_STATE);
        end
        @(negedge CLK); RST_N = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_latency();
        start_capture();
        cyc(1'b1, 16'h2006, 1'b0);
        idle(5);
        n_cmp++;
        if (got_q.size() !== 1) begin
            n_bad++; $display("FAIL latency_count: got %0d pulses required 1", got_q.size());
        end
        if (got_q.size() >= 1) begin
            n_cmp++;
            if (got_q[0] !== 16'h2006) begin
                n_bad++; $display("FAIL latency_data: got %h required 2006", got_q[0]);
            end
            n_cmp++;
            if (got_t[0] !== 2) begin
                n_bad++; $display("FAIL latency_cycle: got N+%0d required N+2", got_t[0]);
            end
        end
    endtask

    task automatic test_retract();
        start_capture();
        exp_q = '{16'h4006, 16'h2004};
        exp_t = '{2, 4};
        cyc(1'b1, 16'h4006, 1'b0);
        idle(7);
        n_cmp++;
        if (got_q.size() !== exp_q.size()) begin
            n_bad++; $display("FAIL retract_count: got %0d pulses required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i] || got_t[i] !== exp_t[i]) begin
                n_bad++;
                $display("FAIL retract_word%0d: got %h@%0d required %h@%0d", i, got_q[i], got_t[i], exp_q[i], exp_t[i]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [15:0] w [6];
        w = '{16'h6002, 16'h0804, 16'h1004, 16'h1804, 16'h9804, 16'h8004};
        n_cmp++;
        if (OVERFLOW !== 1'b0) begin
            n_bad++; $display("FAIL overflow_before: got %b required 0", OVERFLOW);
        end
        start_capture();
        exp_q = '{16'h6002, 16'h4004, 16'h0804, 16'h1004, 16'h1804, 16'h9804};
        exp_t = '{2, 4, 7, 10, 13, 16};
        for (int i = 0; i < 6; i++) cyc(1'b1, w[i], 1'b0);
        idle(14);
        n_cmp++;
        if (got_q.size() !== exp_q.size()) begin
            n_bad++; $display("FAIL overflow_count: got %0d pulses required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i] || got_t[i] !== exp_t[i]) begin
                n_bad++;
                $display("FAIL overflow_word%0d: got %h@%0d required %h@%0d", i, got_q[i], got_t[i], exp_q[i], exp_t[i]);
            end
        end
        n_cmp++;
        if (OVERFLOW !== 1'b1) begin
            n_bad++; $display("FAIL overflow_flag: got %b required 1", OVERFLOW);
        end
    endtask

    task automatic test_bad_coord();
        n_cmp++;
        if (BAD_COORD !== 1'b0) begin
            n_bad++; $display("FAIL bad_before: got %b required 0", BAD_COORD);
        end
        start_capture();
        cyc(1'b1, 16'hA000, 1'b0);
        cyc(1'b1, 16'h2808, 1'b0);
        idle(4);
        n_cmp++;
        if (BAD_COORD !== 1'b1) begin
            n_bad++; $display("FAIL bad_flag: got %b required 1", BAD_COORD);
        end
        n_cmp++;
        if (got_q.size() !== 1) begin
            n_bad++; $display("FAIL bad_count: got %0d pulses required 1", got_q.size());
        end
        if (got_q.size() >= 1) begin
            n_cmp++;
            if (got_q[0] !== 16'h2808 || got_t[0] !== 3) begin
                n_bad++; $display("FAIL bad_next_word: got %h@%0d required 2808@3", got_q[0], got_t[0]);
            end
        end
    endtask

    task automatic test_clear();
        start_capture();
        exp_q.push_back(16'h0005); exp_t.push_back(2);
        for (int k = 0; k < 20; k++) begin
            exp_q.push_back(16'((k / 4) << 13) | 16'((k % 4) << 11));
            exp_t.push_back(5 + 2 * k);
        end
        cyc(1'b1, 16'h0005, 1'b0);
        cyc(1'b1, 16'h0804, 1'b0);
        cyc(1'b1, 16'h1004, 1'b1);
        n_cmp++;
        if (DONE !== 1'b1) begin
            n_bad++; $display("FAIL clear_done_before: got %b required 1", DONE);
        end
        idle(47);
        n_cmp++;
        if (got_q.size() !== exp_q.size()) begin
            n_bad++; $display("FAIL clear_count: got %0d pulses required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i] || got_t[i] !== exp_t[i] || got_b[i] !== (i != 0)) begin
                n_bad++;
                $display("FAIL clear_word%0d: got %h@%0d busy=%b required %h@%0d busy=%b",
                         i, got_q[i], got_t[i], got_b[i], exp_q[i], exp_t[i], (i != 0));
            end
        end
        n_cmp++;
        if (CLEAR_BUSY !== 1'b0 || DONE !== 1'b0) begin
            n_bad++; $display("FAIL clear_after: got busy=%b done=%b required busy=0 done=0", CLEAR_BUSY, DONE);
        end
    endtask

    task automatic test_reset_mid_clear();
        start_capture();
        cyc(1'b1, 16'h0001, 1'b0);
        idle(3);
        cyc(1'b0, 16'h0000, 1'b1);
        idle(5);
        n_cmp++;
        if (got_q.size() < 1 || got_q[0] !== 16'h0001 || got_t[0] !== 2) begin
            n_bad++; $display("FAIL done_word: got %0d pulses, first %h required 0001@2",
                              got_q.size(), (got_q.size() > 0) ? got_q[0] : 16'hxxxx);
        end
        n_cmp++;
        if ({DATA_VAL, DATA_OUT, CLEAR_BUSY, DONE} !== {1'b1, 16'h1000, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL sweep_before_reset: got val=%b out=%h busy=%b done=%b required val=1 out=1000 busy=1 done=1",
                     DATA_VAL, DATA_OUT, CLEAR_BUSY, DONE);
        end
        #2 RST_N = 1'b0;
        #1;
        n_cmp++;
        if ({DATA_OUT, DATA_VAL, CLEAR_BUSY, OVERFLOW, BAD_COORD, DONE, FSM_STATE} !== 24'h0) begin
            n_bad++;
            $display("FAIL async_reset: got out=%h val=%b busy=%b ovf=%b bad=%b done=%b st=%0d required all zero",
                     DATA_OUT, DATA_VAL, CLEAR_BUSY, OVERFLOW, BAD_COORD, DONE, FSM_STATE);
        end
        @(negedge CLK); @(negedge CLK); RST_N = 1'b1;
        @(posedge CLK); #1;
        prev_dv = 1'b0;
        start_capture();
        idle(10);
        n_cmp++;
        if (got_q.size() !== 0 || CLEAR_BUSY !== 1'b0) begin
            n_bad++; $display("FAIL after_reset_quiet: got %0d pulses busy=%b required 0 pulses busy=0",
                              got_q.size(), CLEAR_BUSY);
        end
    endtask

    task automatic test_back_to_back();
        n_cmp++;
        if (adj_cnt !== 0) begin
            n_bad++; $display("FAIL back_to_back: got %0d adjacent pulses required 0", adj_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_retract();
        test_overflow();
        test_bad_coord();
        test_clear();
        test_reset_mid_clear();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
